// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor: one STAGE_W-bit carry-lookahead slice per stage,
// carry registered between stages, valid/ready handshake, signed overflow, zero flag and saturation.
module pipe_add_sub #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N = WIDTH / STAGE_W;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Returns carries c[0..STAGE_W] of one slice in sum-of-products lookahead form.
  function automatic logic [STAGE_W:0] cla(input logic [STAGE_W-1:0] p,
                                           input logic [STAGE_W-1:0] g,
                                           input logic               cin);
    logic [STAGE_W:0] c;
    logic             term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < STAGE_W; i++) begin
      term = cin;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage k holds x (sum slices below k, operand A slices from k up) and the B' slices still to be consumed.
  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int BW = WIDTH - k * STAGE_W;

    logic             v_q, v_d, c_q, c_d, sat_q, sat_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [BW-1:0]    bx_q, bx_d;

    if (k == 0) begin : g_in
      always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        sat_d = sat_q;
        x_d   = x_q;
        bx_d  = bx_q;
        if (en) begin
          v_d   = in_valid;
          c_d   = ctrl;
          sat_d = SAT_EN && sat;
          x_d   = a;
          bx_d  = b ^ {WIDTH{ctrl}};
        end
      end
    end else begin : g_slice
      logic [STAGE_W-1:0] p, g;
      logic [STAGE_W:0]   cl;

      always_comb begin
        p     = g_stage[k-1].x_q[(k-1)*STAGE_W +: STAGE_W] ^ g_stage[k-1].bx_q[STAGE_W-1:0];
        g     = g_stage[k-1].x_q[(k-1)*STAGE_W +: STAGE_W] & g_stage[k-1].bx_q[STAGE_W-1:0];
        cl    = cla(p, g, g_stage[k-1].c_q);
        v_d   = v_q;
        c_d   = c_q;
        sat_d = sat_q;
        x_d   = x_q;
        bx_d  = bx_q;
        if (en) begin
          v_d   = g_stage[k-1].v_q;
          c_d   = cl[STAGE_W];
          sat_d = g_stage[k-1].sat_q;
          x_d   = g_stage[k-1].x_q;
          x_d[(k-1)*STAGE_W +: STAGE_W] = p ^ cl[STAGE_W-1:0];
          bx_d  = g_stage[k-1].bx_q[BW+STAGE_W-1:STAGE_W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sat_q <= 1'b0;
        x_q   <= '0;
        bx_q  <= '0;
      end else begin
        v_q   <= v_d;
        c_q   <= c_d;
        sat_q <= sat_d;
        x_q   <= x_d;
        bx_q  <= bx_d;
      end
    end
  end

  logic             out_valid_q, out_valid_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [WIDTH-1:0] res_q, res_d, sum_f;
  logic [STAGE_W-1:0] p_f, g_f;
  logic [STAGE_W:0]   cl_f;
  logic               ovf_f;

  // Top slice, flags and saturation; A's MSB is still intact in the top slice of x.
  always_comb begin
    p_f   = g_stage[N-1].x_q[WIDTH-1 -: STAGE_W] ^ g_stage[N-1].bx_q;
    g_f   = g_stage[N-1].x_q[WIDTH-1 -: STAGE_W] & g_stage[N-1].bx_q;
    cl_f  = cla(p_f, g_f, g_stage[N-1].c_q);
    sum_f = g_stage[N-1].x_q;
    sum_f[WIDTH-1 -: STAGE_W] = p_f ^ cl_f[STAGE_W-1:0];
    ovf_f = cl_f[STAGE_W] ^ cl_f[STAGE_W-1];
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    res_d       = res_q;
    if (en) begin
      out_valid_d = g_stage[N-1].v_q;
      cout_d      = cl_f[STAGE_W];
      ovf_d       = ovf_f;
      res_d       = sum_f;
      if (g_stage[N-1].sat_q && ovf_f) begin
        res_d = g_stage[N-1].x_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end
      zero_d = (res_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub (WIDTH=16, STAGE_W=4): directed vector table, stall,
// mid-flight reset and a long random stream against an arithmetic reference model.
module tb_pipe_add_sub;

  localparam int WIDTH   = 16;
  localparam int STAGE_W = 4;
  localparam int N       = WIDTH / STAGE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, ctrl, sat, out_valid, out_ready, cout, ovf, zero;
  logic [WIDTH-1:0]  a, b, res;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ctrl;
    logic        sat;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[12];
  logic [15:0] stall_a[8];
  logic [15:0] stall_b[8];

  pipe_add_sub #(.WIDTH(WIDTH), .STAGE_W(STAGE_W), .SAT_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .ctrl     (ctrl),
    .sat      (sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: exact signed result decides overflow and clamp direction.
  function automatic exp_t refModel(input logic [15:0] a_i, input logic [15:0] b_i,
                                    input logic ctrl_i, input logic sat_i);
    logic [16:0] full;
    logic [15:0] b_eff;
    int          sa, sb, ex;
    exp_t        e;
    b_eff  = ctrl_i ? ~b_i : b_i;
    full   = {1'b0, a_i} + {1'b0, b_eff} + {16'b0, ctrl_i};
    sa     = int'($signed(a_i));
    sb     = int'($signed(b_i));
    ex     = ctrl_i ? sa - sb : sa + sb;
    e.ovf  = (ex > 32767) || (ex < -32768);
    e.cout = full[16];
    e.res  = (sat_i && e.ovf) ? ((ex > 0) ? 16'h7FFF : 16'h8000) : full[15:0];
    e.zero = (e.res == 16'h0000);
    return e;
  endfunction

  function automatic logic [15:0] pickOperand();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h0000;
      1:       v = 16'h7FFF;
      2:       v = 16'h8000;
      3:       v = 16'hFFFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] a_i, input logic [15:0] b_i,
                               input logic c_i, input logic s_i);
    in_valid = v;
    a        = a_i;
    b        = b_i;
    ctrl     = c_i;
    sat      = s_i;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compareResult(input string tag, input exp_t e);
    checkOutput({tag, " res"},  res,          e.res);
    checkOutput({tag, " cout"}, {15'b0, cout}, {15'b0, e.cout});
    checkOutput({tag, " ovf"},  {15'b0, ovf},  {15'b0, e.ovf});
    checkOutput({tag, " zero"}, {15'b0, zero}, {15'b0, e.zero});
  endtask

  // One beat on an idle pipe; out_valid must rise exactly N edges after the accept edge.
  task automatic runSingle(input string tag, input vec_t v);
    exp_t e;
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, v.a, v.b, v.ctrl, v.sat);
    #1 checkOutput({tag, " in_ready"}, {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int n = 0; n <= N; n++) begin
      if (n > 0) @(negedge clk);
      #1 checkOutput($sformatf("%s out_valid@%0d", tag, n), {15'b0, out_valid}, {15'b0, (n == N)});
    end
    e.res  = v.res;
    e.cout = v.cout;
    e.ovf  = v.ovf;
    e.zero = v.zero;
    compareResult(tag, e);
  endtask

  // Streams beats through a scoreboard; operands stay stable until accepted.
  task automatic runStream(input string tag, input int beats, input bit rnd,
                           input int stall_at, input int stall_len, input int max_cycles);
    int          sent, got, cyc;
    bit          pend;
    logic [15:0] na, nb;
    logic        nc, ns;
    bit          in_stall;
    exp_t        e;
    sent = 0; got = 0; cyc = 0; pend = 1'b0;
    na = '0; nb = '0; nc = 1'b0; ns = 1'b0;
    while ((sent < beats || sb_q.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      if (!pend && sent < beats) begin
        if (rnd) begin
          na = pickOperand(); nb = pickOperand();
          nc = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
          pend = ($urandom_range(0, 9) < 8);
        end else begin
          na = stall_a[sent]; nb = stall_b[sent];
          nc = sent[0]; ns = sent[1];
          pend = 1'b1;
        end
      end
      applyStimulus(pend, na, nb, nc, ns);
      in_stall  = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = in_stall ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      #1;
      checkOutput({tag, " in_ready"}, {15'b0, in_ready}, {15'b0, (!out_valid || out_ready)});
      if (in_stall) begin
        checkOutput({tag, " stall out_valid"}, {15'b0, out_valid}, 16'd1);
        checkOutput({tag, " stall in_ready"}, {15'b0, in_ready}, 16'd0);
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL %s unexpected result: got res=0x%0h, expected no result", tag, res);
        end else if (out_ready) begin
          e = sb_q.pop_front();
          compareResult(tag, e);
          got++;
        end else begin
          compareResult({tag, " held"}, sb_q[0]);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(refModel(na, nb, nc, ns));
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    checkOutput({tag, " results received"}, 16'(got), 16'(beats));
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s timeout: got %0d results pending, expected 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    //           a         b      ctrl  sat   res    cout  ovf   zero
    vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h00FF, 16'hFF01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};

    stall_a = '{16'h0001, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0F0F, 16'h4000, 16'hABCD};
    stall_b = '{16'h0002, 16'h0001, 16'h0001, 16'h4321, 16'hFFFF, 16'hF0F0, 16'h4000, 16'h1111};

    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset in_ready",  {15'b0, in_ready},  16'd1);
    checkOutput("reset out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("reset res",       res,                16'h0000);
    checkOutput("reset cout",      {15'b0, cout},      16'd0);
    checkOutput("reset ovf",       {15'b0, ovf},       16'd0);
    checkOutput("reset zero",      {15'b0, zero},      16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      runSingle($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    runStream("stall", 8, 1'b0, 6, 3, 200);

    // Five beats with the consumer stalled: the first result sits at the output, the rest in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("pre-reset out_valid", {15'b0, out_valid}, 16'd1);
    checkOutput("pre-reset res",       res,                16'h2222);
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", {15'b0, out_valid}, 16'd0);
    checkOutput("midrst res",       res,                16'h0000);
    checkOutput("midrst cout",      {15'b0, cout},      16'd0);
    checkOutput("midrst zero",      {15'b0, zero},      16'd0);
    checkOutput("midrst in_ready",  {15'b0, in_ready},  16'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("post-reset idle %0d", i), {15'b0, out_valid}, 16'd0);
    end
    v = '{16'h0100, 16'h0023, 1'b1, 1'b0, 16'h00DD, 1'b1, 1'b0, 1'b0};
    runSingle("post-reset beat", v);
    @(negedge clk);

    runStream("random", 10000, 1'b1, -1, 0, 60000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
